// File: rtl/spu_dispatch_pkg.sv
// spu_dispatch_pkg: shared types, nop encodings and decode helpers for dual_issue_dispatch
package spu_dispatch_pkg;
    typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        predict;
        logic [31:0] predict_pc;
    } entry_t;
    typedef struct packed {
        pipe_e      pipe;
        logic [2:0] unit;
    } cls_t;
    localparam logic [2:0] UNIT_NONE = 3'd0;
    localparam logic [2:0] UNIT_FX   = 3'd1;
    localparam logic [2:0] UNIT_FP   = 3'd2;
    localparam logic [2:0] UNIT_LS   = 3'd3;
    localparam logic [2:0] UNIT_BR   = 3'd4;
    localparam logic [2:0] UNIT_SH   = 3'd5;
    localparam logic [34:0] NOP_EVEN = {11'b01000000001, 21'b0, 3'b000};
    localparam logic [34:0] NOP_ODD  = {11'b00000000001, 21'b0, 3'b000};
    function automatic cls_t classify(input logic [31:0] instr);
        cls_t c;
        c = '{PIPE_EVEN, UNIT_NONE};
        if (instr[31:21] == 11'b00011000000) c = '{PIPE_EVEN, UNIT_FX};
        else if (instr[31:28] == 4'b1110) c = '{PIPE_EVEN, UNIT_FP};
        else if (instr[31:24] == 8'b00110100) c = '{PIPE_ODD, UNIT_LS};
        else if (instr[31:23] == 9'b001100100) c = '{PIPE_ODD, UNIT_BR};
        else if (instr[31:28] == 4'b1011) c = '{PIPE_ODD, UNIT_SH};
        return c;
    endfunction
    function automatic logic [6:0] rt_of(input logic [31:0] instr);
        return (instr[31:28] == 4'b1100 || instr[31:28] == 4'b1110 || instr[31:28] == 4'b1111)
            ? instr[27:21] : instr[6:0];
    endfunction
endpackage

// File: rtl/dual_issue_dispatch_fifo.sv
// dispatch_fifo: two-entry-write circular buffer exposing the two oldest entries
module dispatch_fifo
    import spu_dispatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [1:0]    pop,
    input  entry_t        wr0,
    input  entry_t        wr1,
    output entry_t        head0,
    output entry_t        head1,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q, wr_nxt, rd_nxt;
    logic [CW-1:0] count_d, count_q;
    always_comb begin
        wr_nxt = wr_ptr_q + AW'(1);
        rd_nxt = rd_ptr_q + AW'(1);
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr0;
            mem_d[wr_nxt] = wr1;
        end
        wr_ptr_d = flush ? '0 : wr_ptr_q + (push ? AW'(2) : AW'(0));
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d = flush ? '0 : count_q + (push ? CW'(2) : CW'(0)) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_nxt];
    assign count = count_q;
endmodule

// File: rtl/dual_issue_dispatch.sv
// dual_issue_dispatch: instruction queue + even/odd pairing dispatcher; DISPATCH_PERF_CNT_EN adds perf counters
module dual_issue_dispatch
    import spu_dispatch_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_instr0,
    input  logic [31:0] fetch_instr1,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_predict,
    input  logic [31:0] fetch_predict_pc,
    input  logic        flush,
    output logic [34:0] instructionEven,
    output logic [34:0] instructionOdd,
    output logic [31:0] PCout,
    output logic        predictOut,
    output logic [31:0] predictPCout
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_single,
    output logic [31:0] perf_empty
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    entry_t        wr0, wr1, a, b, e, o;
    cls_t          ca, cb, ce, co;
    logic [CW-1:0] count;
    logic [1:0]    pop;
    logic          push, dual, hazard, even_v, odd_v;
    logic [34:0]   even_d, even_q, odd_d, odd_q;
    logic [31:0]   pc_d, pc_q, ppc_d, ppc_q;
    logic          pred_d, pred_q;
    assign fetch_ready = reset && (CW'(DEPTH) - count >= CW'(2));
    assign push = fetch_valid && fetch_ready && !flush;
    assign wr0 = '{fetch_instr0, fetch_pc, fetch_predict, fetch_predict_pc};
    assign wr1 = '{fetch_instr1, fetch_pc + 32'd4, fetch_predict, fetch_predict_pc};
    dispatch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
        .wr0(wr0), .wr1(wr1), .head0(a), .head1(b), .count(count)
    );
    // Register-field overlap is checked on raw bit positions, so some safe pairs single-issue.
    always_comb begin
        ca = classify(a.instr);
        cb = classify(b.instr);
        hazard = rt_of(a.instr) == b.instr[20:14] || rt_of(a.instr) == b.instr[13:7]
              || rt_of(a.instr) == b.instr[6:0] || rt_of(a.instr) == rt_of(b.instr);
        dual = count >= CW'(2) && ca.pipe != cb.pipe && !hazard;
        pop = (flush || count == '0) ? 2'd0 : dual ? 2'd2 : 2'd1;
        e = ca.pipe == PIPE_EVEN ? a : b;
        ce = ca.pipe == PIPE_EVEN ? ca : cb;
        o = ca.pipe == PIPE_ODD ? a : b;
        co = ca.pipe == PIPE_ODD ? ca : cb;
        even_v = pop == 2'd2 || (pop == 2'd1 && ca.pipe == PIPE_EVEN);
        odd_v = pop == 2'd2 || (pop == 2'd1 && ca.pipe == PIPE_ODD);
        even_d = even_v ? {e.instr, ce.unit} : NOP_EVEN;
        odd_d = odd_v ? {o.instr, co.unit} : NOP_ODD;
        pc_d = odd_v ? o.pc : '0;
        pred_d = odd_v && o.predict;
        ppc_d = odd_v ? o.predict_pc : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            even_q <= NOP_EVEN;
            odd_q <= NOP_ODD;
            pc_q <= '0;
            pred_q <= 1'b0;
            ppc_q <= '0;
        end else begin
            even_q <= even_d;
            odd_q <= odd_d;
            pc_q <= pc_d;
            pred_q <= pred_d;
            ppc_q <= ppc_d;
        end
    end
    assign instructionEven = even_q;
    assign instructionOdd = odd_q;
    assign PCout = pc_q;
    assign predictOut = pred_q;
    assign predictPCout = ppc_q;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] perf_dual_d, perf_dual_q, perf_single_d, perf_single_q, perf_empty_d, perf_empty_q;
    always_comb begin
        perf_dual_d = perf_dual_q + 32'(pop == 2'd2 && perf_dual_q != '1);
        perf_single_d = perf_single_q + 32'(pop == 2'd1 && perf_single_q != '1);
        perf_empty_d = perf_empty_q + 32'(!flush && count == '0 && perf_empty_q != '1);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_dual_q <= '0;
            perf_single_q <= '0;
            perf_empty_q <= '0;
        end else begin
            perf_dual_q <= perf_dual_d;
            perf_single_q <= perf_single_d;
            perf_empty_q <= perf_empty_d;
        end
    end
    assign perf_dual = perf_dual_q;
    assign perf_single = perf_single_q;
    assign perf_empty = perf_empty_q;
`endif
endmodule

// File: tb/tb_dual_issue_dispatch.sv
// tb_dual_issue_dispatch: directed scoreboard bench for dual_issue_dispatch
module tb_dual_issue_dispatch;
    typedef struct packed {
        logic [34:0] e;
        logic [34:0] o;
        logic [31:0] pc;
        logic        p;
        logic [31:0] ppc;
    } pkt_t;
    localparam logic [34:0] NE = {11'b01000000001, 24'b0};
    localparam logic [34:0] NO = {11'b00000000001, 24'b0};
    logic        clk = 1'b0, reset, fetch_valid, fetch_ready, fetch_predict, flush, predictOut;
    logic [31:0] fetch_instr0, fetch_instr1, fetch_pc, fetch_predict_pc, PCout, predictPCout;
    logic [34:0] instructionEven, instructionOdd;
    int          n_asrt = 0, n_fail = 0;
    pkt_t        sb[$];
    always #5 clk = ~clk;
    dual_issue_dispatch dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1), .fetch_pc(fetch_pc),
        .fetch_predict(fetch_predict), .fetch_predict_pc(fetch_predict_pc), .flush(flush),
        .instructionEven(instructionEven), .instructionOdd(instructionOdd), .PCout(PCout),
        .predictOut(predictOut), .predictPCout(predictPCout)
    );
    function automatic logic [31:0] op_a(int rt, int ra, int rb);
        return {11'b00011000000, 7'(rb), 7'(ra), 7'(rt)};
    endfunction
    function automatic logic [31:0] op_fma(int rt, int ra, int rb, int rc);
        return {4'b1110, 7'(rt), 7'(rb), 7'(ra), 7'(rc)};
    endfunction
    function automatic logic [31:0] op_lqd(int rt, int ra);
        return {8'b00110100, 10'd0, 7'(ra), 7'(rt)};
    endfunction
    function automatic logic [31:0] op_shufb(int rt);
        return {4'b1011, 7'(rt), 7'd1, 7'd2, 7'd3};
    endfunction
    function automatic pkt_t pe(logic [31:0] i, logic [2:0] u);
        return '{{i, u}, NO, 32'd0, 1'b0, 32'd0};
    endfunction
    function automatic pkt_t po(logic [31:0] i, logic [2:0] u, logic [31:0] pc, logic p, logic [31:0] ppc);
        return '{NE, {i, u}, pc, p, ppc};
    endfunction
    function automatic pkt_t pd(logic [31:0] ei, logic [2:0] eu, logic [31:0] oi, logic [2:0] ou, logic [31:0] pc);
        return '{{ei, eu}, {oi, ou}, pc, 1'b0, 32'd0};
    endfunction
    task automatic chk(input string tag, input logic [134:0] got, input logic [134:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        pkt_t got, exp;
        @(posedge clk);
        #1;
        got = '{instructionEven, instructionOdd, PCout, predictOut, predictPCout};
        if (instructionEven !== NE || instructionOdd !== NO) begin
            if (sb.size() != 0) exp = sb.pop_front();
            else exp = '{NE, NO, 32'd0, 1'b0, 32'd0};
            chk("issue", got, exp);
        end
    endtask
    task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc,
                         input logic p, input logic [31:0] ppc);
        fetch_valid = 1'b1;
        fetch_instr0 = i0;
        fetch_instr1 = i1;
        fetch_pc = pc;
        fetch_predict = p;
        fetch_predict_pc = ppc;
    endtask
    task automatic idle(input int n);
        fetch_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask
    initial begin
        reset = 1'b0;
        flush = 1'b0;
        drive('0, '0, '0, 1'b0, '0);
        fetch_valid = 1'b0;
        idle(2);
        chk("rst_out", {instructionEven, instructionOdd, PCout, predictOut, predictPCout},
            {NE, NO, 32'd0, 1'b0, 32'd0});
        chk("rst_ready", fetch_ready, 0);
        reset = 1'b1;
        idle(1);
        chk("ready_after_rst", fetch_ready, 1);
        chk("count_after_rst", dut.count, 0);
        // even+odd pair dual-issues one cycle after the push
        drive(op_a(3, 1, 2), op_lqd(4, 9), 32'h100, 1'b0, 32'h0);
        sb.push_back(pd(op_a(3, 1, 2), 3'd1, op_lqd(4, 9), 3'd3, 32'h104));
        step();
        chk("latency", {instructionEven, instructionOdd}, {NE, NO});
        chk("count_2", dut.count, 2);
        idle(1);
        chk("dual_drained", sb.size(), 0);
        chk("count_0", dut.count, 0);
        // both even -> two single issues in order
        drive(op_a(3, 1, 2), op_fma(5, 6, 7, 8), 32'h200, 1'b0, 32'h0);
        sb.push_back(pe(op_a(3, 1, 2), 3'd1));
        sb.push_back(pe(op_fma(5, 6, 7, 8), 3'd2));
        step();
        idle(3);
        chk("same_pipe", sb.size(), 0);
        // RAW dependency forces split
        drive(op_a(7, 1, 2), op_lqd(10, 7), 32'h300, 1'b0, 32'h0);
        sb.push_back(pe(op_a(7, 1, 2), 3'd1));
        sb.push_back(po(op_lqd(10, 7), 3'd3, 32'h304, 1'b0, 32'h0));
        step();
        idle(3);
        chk("raw_split", sb.size(), 0);
        // unknown opcode goes even; odd-then-even pair swaps slots; WAW splits
        drive(32'h0000_0015, op_lqd(4, 9), 32'h400, 1'b0, 32'h0);
        sb.push_back(pd(32'h0000_0015, 3'd0, op_lqd(4, 9), 3'd3, 32'h404));
        step();
        idle(2);
        drive(op_lqd(4, 9), op_fma(5, 6, 7, 8), 32'h500, 1'b0, 32'h0);
        sb.push_back(pd(op_fma(5, 6, 7, 8), 3'd2, op_lqd(4, 9), 3'd3, 32'h500));
        step();
        idle(2);
        drive(op_a(3, 1, 2), op_lqd(3, 9), 32'h600, 1'b0, 32'h0);
        sb.push_back(pe(op_a(3, 1, 2), 3'd1));
        sb.push_back(po(op_lqd(3, 9), 3'd3, 32'h604, 1'b0, 32'h0));
        step();
        idle(3);
        chk("mixed_pairs", sb.size(), 0);
        // predicted branch on odd pipe carries sideband
        drive(32'h3200_1000, op_shufb(20), 32'h700, 1'b1, 32'h200);
        sb.push_back(po(32'h3200_1000, 3'd4, 32'h700, 1'b1, 32'h200));
        sb.push_back(po(op_shufb(20), 3'd5, 32'h704, 1'b1, 32'h200));
        step();
        idle(3);
        chk("branch_pred", sb.size(), 0);
        // fill to DEPTH-1 with even-only singles
        for (int i = 0; i < 6; i++) begin
            drive(op_a(10 + i, 1, 2), op_a(20 + i, 1, 2), 32'h1000 + 32'(8 * i), 1'b0, 32'h0);
            sb.push_back(pe(op_a(10 + i, 1, 2), 3'd1));
            sb.push_back(pe(op_a(20 + i, 1, 2), 3'd1));
            step();
        end
        chk("full_count", dut.count, 7);
        chk("full_ready", fetch_ready, 0);
        drive(op_a(40, 1, 2), op_a(41, 1, 2), 32'h1800, 1'b0, 32'h0);
        step();
        chk("ignored_push_count", dut.count, 6);
        chk("ready_restored", fetch_ready, 1);
        idle(12);
        chk("full_drained", sb.size(), 0);
        chk("full_count_0", dut.count, 0);
        // flush with 6 queued and a simultaneous push
        for (int i = 0; i < 5; i++) begin
            drive(op_a(50 + i, 1, 2), op_a(60 + i, 1, 2), 32'h2000 + 32'(8 * i), 1'b0, 32'h0);
            sb.push_back(pe(op_a(50 + i, 1, 2), 3'd1));
            sb.push_back(pe(op_a(60 + i, 1, 2), 3'd1));
            step();
        end
        chk("pre_flush_count", dut.count, 6);
        flush = 1'b1;
        drive(op_a(70, 1, 2), op_lqd(71, 9), 32'h2800, 1'b1, 32'h300);
        step();
        flush = 1'b0;
        fetch_valid = 1'b0;
        chk("flush_out", {instructionEven, instructionOdd, PCout, predictOut, predictPCout},
            {NE, NO, 32'd0, 1'b0, 32'd0});
        chk("flush_count", dut.count, 0);
        sb.delete();
        idle(6);
        chk("post_flush_count", dut.count, 0);
        // mid-operation reset discards queued work
        drive(op_a(3, 1, 2), op_fma(5, 6, 7, 8), 32'h3000, 1'b0, 32'h0);
        step();
        fetch_valid = 1'b0;
        reset = 1'b0;
        step();
        chk("midrst_out", {instructionEven, instructionOdd}, {NE, NO});
        chk("midrst_ready", fetch_ready, 0);
        chk("midrst_count", dut.count, 0);
        reset = 1'b1;
        idle(4);
        chk("midrst_after", dut.count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
